// File: rtl/spi_load_scheduler_pkg.sv
// Shared kernel package for the SPI load scheduler: FSM state
// encoding and the AXI 4 KB page constant used by burst splitting.
package spi_load_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    localparam int unsigned PAGE_BYTES = 4096;

endpackage

// File: rtl/burst_len_calc.sv
// Combinational burst sizer: beats for the next command, limited by
// remaining beats, C_MAX_BEATS and the distance to the next 4 KB page.
// Ports: page_off_i  low 12 address bits (beat aligned)
//        remaining_i beats still to request
//        beats_o     beats for this burst
module burst_len_calc
    import spi_load_scheduler_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_MAX_BEATS  = 256
) (
    input  logic [11:0] page_off_i,
    input  logic [31:0] remaining_i,
    output logic [31:0] beats_o
);

    localparam int unsigned BPB  = C_DATA_WIDTH / 8;
    localparam int unsigned OFFW = $clog2(BPB);

    logic [31:0] page_beats;
    logic [31:0] lim;

    always_comb begin
        page_beats = (PAGE_BYTES - {20'd0, page_off_i}) >> OFFW;
        lim = (remaining_i < C_MAX_BEATS) ? remaining_i : C_MAX_BEATS;
        beats_o = (page_beats < lim) ? page_beats : lim;
    end

endmodule

// File: rtl/spi_load_scheduler.sv
// Splits a beat-count load request into AXI read bursts that never cross
// a 4 KB page, with a cap on outstanding bursts.
// Ports: ap_clk/areset (sync, active-high); start, spi_enable, base_addr,
//        instr_num request; cmd_valid/cmd_ready, cmd_addr, cmd_len burst
//        command; cmp_valid burst completion; busy, done, err status.
module spi_load_scheduler
    import spi_load_scheduler_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_DATA_WIDTH      = 32,
    parameter int unsigned C_MAX_BEATS       = 256,
    parameter int unsigned C_MAX_OUTSTANDING = 4
) (
    input  logic                    ap_clk,
    input  logic                    areset,
    input  logic                    start,
    input  logic                    spi_enable,
    input  logic [C_ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]             instr_num,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [C_ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]              cmd_len,
    input  logic                    cmp_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned BPB  = C_DATA_WIDTH / 8;
    localparam int unsigned OFFW = $clog2(BPB);
    localparam int unsigned OW   = $clog2(C_MAX_OUTSTANDING + 1);
    localparam logic [C_ADDR_WIDTH-1:0] ALIGN_MASK =
        ~C_ADDR_WIDTH'(BPB - 1);

    state_e                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]             rem_q, rem_d;
    logic [31:0]             beats_q, beats_d;
    logic [C_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [7:0]              cmd_len_q, cmd_len_d;
    logic [OW-1:0]           out_q, out_d;
    logic                    err_q, err_d;

    logic        hs;
    logic [31:0] calc_beats;

    burst_len_calc #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_MAX_BEATS  (C_MAX_BEATS)
    ) u_calc (
        .page_off_i  (addr_q[11:0]),
        .remaining_i (rem_q),
        .beats_o     (calc_beats)
    );

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            beats_q    <= '0;
            cmd_addr_q <= '0;
            cmd_len_q  <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            beats_q    <= beats_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_len_q  <= cmd_len_d;
            out_q      <= out_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (spi_enable && instr_num != 0) ? CALC : DONE;
                end
            end
            CALC:  state_d = ISSUE;
            ISSUE: begin
                if (hs) begin
                    state_d = (rem_q != beats_q) ? CALC : DRAIN;
                end
            end
            DRAIN: begin
                if (out_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = (state_q == ISSUE) && (out_q < OW'(C_MAX_OUTSTANDING));
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        err       = err_q;
        cmd_addr  = cmd_addr_q;
        cmd_len   = cmd_len_q;
    end

    assign hs = cmd_valid && cmd_ready;

    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        beats_d    = beats_q;
        cmd_addr_d = cmd_addr_q;
        cmd_len_d  = cmd_len_q;
        out_d      = out_q;
        err_d      = err_q;
        if (state_q == IDLE && start) begin
            addr_d = base_addr & ALIGN_MASK;
            rem_d  = instr_num;
            err_d  = 1'b0;
        end
        if (state_q == CALC) begin
            beats_d    = calc_beats;
            cmd_addr_d = addr_q;
            cmd_len_d  = 8'(calc_beats - 32'd1);
        end
        if (hs) begin
            addr_d = addr_q + (C_ADDR_WIDTH'(beats_q) << OFFW);
            rem_d  = rem_q - beats_q;
        end
        // Simultaneous issue and completion cancel; a completion with
        // nothing outstanding is a protocol error and must not wrap.
        unique case ({hs, cmp_valid})
            2'b10: out_d = out_q + OW'(1);
            2'b01: begin
                if (out_q != '0) begin
                    out_d = out_q - OW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            default: out_d = out_q;
        endcase
    end

endmodule

// File: tb/tb_spi_load_scheduler.sv
// Scoreboard bench for spi_load_scheduler: expected bursts are planned
// from page/beat arithmetic and checked by an independent monitor.
module tb_spi_load_scheduler;

    logic        ap_clk = 1'b0;
    logic        areset;
    logic        start;
    logic        spi_enable;
    logic [63:0] base_addr;
    logic [31:0] instr_num;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmp_valid;
    logic        busy;
    logic        done;
    logic        err;

    always #5 ap_clk = ~ap_clk;

    spi_load_scheduler dut (
        .ap_clk     (ap_clk),
        .areset     (areset),
        .start      (start),
        .spi_enable (spi_enable),
        .base_addr  (base_addr),
        .instr_num  (instr_num),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmp_valid  (cmp_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } cmd_t;

    int   vectors = 0;
    int   miscompares = 0;
    cmd_t exp_q[$];
    cmd_t mon_e;
    int   tb_out = 0;
    int   hs_cnt = 0;
    int   rdy_mode = 0;
    logic rdy_rand = 1'b1;
    logic cmp_auto = 1'b0;
    logic cmp_rand = 1'b0;
    logic cmp_force = 1'b0;
    logic pv = 1'b0;
    logic [63:0] pa = '0;
    logic [7:0]  pl = '0;

    assign cmd_ready = (rdy_mode == 0) ? 1'b1 :
                       (rdy_mode == 1) ? rdy_rand : 1'b0;
    assign cmp_valid = cmp_auto ? cmp_rand : cmp_force;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: 32-bit beats, 4 bytes per beat, at most 256 beats,
    // no burst crosses a 4096-byte page.
    task automatic plan(logic [63:0] base, logic [31:0] num);
        logic [63:0]     a;
        longint unsigned r;
        longint unsigned page;
        longint unsigned b;
        a = base & ~64'd3;
        r = num;
        while (r > 0) begin
            page = (64'd4096 - (a & 64'hFFF)) / 4;
            b = r;
            if (b > 256) b = 256;
            if (b > page) b = page;
            exp_q.push_back('{addr: a, len: 8'(b - 1)});
            a = a + 64'(b * 4);
            r = r - b;
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic do_start(logic en, logic [63:0] base, logic [31:0] num);
        start = 1'b1;
        spi_enable = en;
        base_addr = base;
        instr_num = num;
        if (en && num != 0) plan(base, num);
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(int maxc, string name);
        for (int i = 0; i < maxc; i++) begin
            @(negedge ap_clk);
            if (done) break;
        end
        chk(name, done, 1);
        cyc(1);
    endtask

    always @(posedge ap_clk) begin
        #1;
        rdy_rand = ($urandom_range(0, 2) != 0);
        cmp_rand = (tb_out > 0) && ($urandom_range(0, 3) == 0);
    end

    always @(negedge ap_clk) begin
        if (areset) begin
            exp_q.delete();
            tb_out = 0;
            pv = 1'b0;
        end else begin
            if (pv) begin
                chk("valid_held", cmd_valid, 1);
                chk("addr_stable", cmd_addr, pa);
                chk("len_stable", cmd_len, pl);
            end
            if (cmd_valid) chk("outstanding_limit", tb_out < 4, 1);
            if (cmd_valid && cmd_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("cmd_addr", cmd_addr, mon_e.addr);
                    chk("cmd_len", cmd_len, mon_e.len);
                end
            end
            if (cmd_valid && cmd_ready && !cmp_valid) begin
                tb_out++;
            end else if (cmp_valid && !(cmd_valid && cmd_ready) && tb_out > 0) begin
                tb_out--;
            end
            if (done) begin
                chk("done_all_issued", exp_q.size(), 0);
                chk("done_drained", tb_out, 0);
            end
            pv = cmd_valid && !cmd_ready;
            pa = cmd_addr;
            pl = cmd_len;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        en;
        logic [31:0] num;
        logic [63:0] base;

        areset = 1'b1;
        start = 1'b0;
        spi_enable = 1'b0;
        base_addr = '0;
        instr_num = '0;
        cyc(3);
        @(negedge ap_clk);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", cmd_addr, 0);
        chk("rst_len", cmd_len, 0);
        cyc(1);
        areset = 1'b0;
        cyc(1);

        // single burst, latency and drain timing
        rdy_mode = 0;
        cmp_auto = 1'b0;
        do_start(1'b1, 64'h1000, 32'd16);
        @(negedge ap_clk);
        chk("t1_no_valid", cmd_valid, 0);
        chk("t1_busy", busy, 1);
        @(negedge ap_clk);
        chk("t2_valid", cmd_valid, 1);
        chk("t2_addr", cmd_addr, 64'h1000);
        chk("t2_len", cmd_len, 15);
        cyc(2);
        cmp_force = 1'b1;
        cyc(1);
        cmp_force = 1'b0;
        @(negedge ap_clk);
        chk("drain_no_done", done, 0);
        @(negedge ap_clk);
        chk("done_after_cmp", done, 1);
        cyc(1);

        // multi-burst and page crossing
        cmp_auto = 1'b1;
        do_start(1'b1, 64'h0, 32'd600);
        wait_done(300, "done_600");
        do_start(1'b1, 64'hFF0, 32'd8);
        wait_done(300, "done_page");

        // outstanding cap
        cmp_auto = 1'b0;
        cmp_force = 1'b0;
        hs_cnt = 0;
        do_start(1'b1, 64'h0, 32'd2048);
        cyc(20);
        @(negedge ap_clk);
        chk("four_outstanding", hs_cnt, 4);
        chk("stalled_valid", cmd_valid, 0);
        cyc(1);
        cmp_force = 1'b1;
        cyc(1);
        cmp_force = 1'b0;
        cyc(5);
        @(negedge ap_clk);
        chk("fifth_cmd", hs_cnt, 5);
        cyc(1);
        cmp_auto = 1'b1;
        wait_done(2000, "done_2048");

        // degenerate starts and error flag
        cmp_auto = 1'b0;
        do_start(1'b1, 64'h40, 32'd0);
        @(negedge ap_clk);
        chk("zero_done_t1", done, 1);
        chk("zero_no_valid", cmd_valid, 0);
        cyc(1);
        do_start(1'b0, 64'h40, 32'd16);
        @(negedge ap_clk);
        chk("dis_done_t1", done, 1);
        chk("dis_no_valid", cmd_valid, 0);
        cyc(1);
        cmp_force = 1'b1;
        cyc(1);
        cmp_force = 1'b0;
        @(negedge ap_clk);
        chk("err_set", err, 1);
        cyc(1);
        cmp_auto = 1'b1;
        do_start(1'b1, 64'h100, 32'd4);
        @(negedge ap_clk);
        chk("err_cleared", err, 0);
        wait_done(300, "done_after_err");

        // reset mid-issue
        cmp_auto = 1'b0;
        rdy_mode = 2;
        do_start(1'b1, 64'h0, 32'd600);
        cyc(3);
        @(negedge ap_clk);
        chk("stall_valid", cmd_valid, 1);
        @(posedge ap_clk);
        #1;
        areset = 1'b1;
        cyc(1);
        areset = 1'b0;
        @(negedge ap_clk);
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_addr", cmd_addr, 0);
        chk("mid_rst_len", cmd_len, 0);
        cyc(1);
        cmp_force = 1'b1;
        cyc(1);
        cmp_force = 1'b0;
        @(negedge ap_clk);
        chk("late_cmp_err", err, 1);
        cyc(1);
        rdy_mode = 1;
        cmp_auto = 1'b1;
        do_start(1'b1, 64'h3F8, 32'd100);
        wait_done(2000, "done_post_rst");

        // randomized requests
        for (int k = 0; k < 15; k++) begin
            en = ($urandom_range(0, 7) != 0);
            num = ($urandom_range(0, 5) == 0) ? 32'd0 :
                  32'($urandom_range(1, 1200));
            base = {$urandom(), $urandom()};
            do_start(en, base, num);
            if (!en || num == 0) begin
                @(negedge ap_clk);
                chk("rand_direct_done", done, 1);
                cyc(1);
            end else begin
                wait_done(20000, "rand_done");
            end
        end

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
